tri_bus_ctrl: RTL and testbench
===============================

Name: tri_bus_ctrl

Overview:
Half-duplex serial controller that generates the data (I) and enable (C) inputs of the tri_state_port buffer stage and samples the shared line back.
- Transmit: accepts a WIDTH-bit word, shifts it MSB-first onto the line with the buffer enabled, then releases the line for a turnaround gap.
- Receive: listens for a WIDTH-bit reply from the far end.
- Detects bus collisions while driving.
- Sits directly upstream of tri_state_port: bus_i feeds I, bus_c feeds C.

Parameters:
WIDTH, 8, bits per transmitted and received word
BIT_CYCLES, 4, clock cycles per bit; must be >= 3 to cover the 2-flop input synchronizer
TURN_CYCLES, 2, clock cycles the line is released between the drive and listen phases

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
tx_data  input  WIDTH  word to transmit; captured on handshake
tx_valid  input  1  transmit request
tx_ready  output  1  high only in IDLE; handshake occurs when tx_valid && tx_ready
bus_i  output  1  data to buffer stage (I)
bus_c  output  1  buffer enable (C); 1 = drive line, 0 = released
bus_in  input  1  asynchronous line readback; passed through a 2-flop synchronizer (sync_in)
rx_data  output  WIDTH  received word; valid when rx_valid is high, holds until next reception
rx_valid  output  1  one-cycle pulse
col_err  output  1  one-cycle pulse on collision

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, tx_ready=1, bus_i=0, bus_c=0, rx_data=0, rx_valid=0, col_err=0, synchronizer flops=0, all counters=0.
- Reset mid-operation: releases the line immediately (bus_c=0), no rx_valid/col_err pulse, returns to IDLE.
- State set: IDLE, DRIVE, TURN, LISTEN. Each state has a cycle counter (0..BIT_CYCLES-1) and a bit counter (0..WIDTH-1).
- IDLE: bus_c=0, bus_i=0, tx_ready=1.
  - On handshake at edge T0: shift register <= tx_data; state -> DRIVE.
  - tx_valid while not in IDLE is ignored; no queuing.
- DRIVE, cycles T1..T(WIDTH*BIT_CYCLES): bus_c=1, bus_i = current bit, MSB first. Each bit is held exactly BIT_CYCLES cycles.
  - Collision check: on the last cycle of each bit (cycle counter = BIT_CYCLES-1), compare sync_in against bus_i.
  - Mismatch: col_err=1 for the next cycle, bus_c=0 from that cycle, go to TURN. LISTEN is skipped; after TURN, return to IDLE.
  - No mismatch after the last bit: go to TURN.
- TURN, TURN_CYCLES cycles: bus_c=0, bus_i=0. Then go to LISTEN, or to IDLE if aborted by collision.
- LISTEN, WIDTH*BIT_CYCLES cycles: bus_c=0.
  - On the last cycle of each bit, shift sync_in into the receive register, MSB first.
  - After the final sample, the next cycle: rx_data updated, rx_valid=1 for one cycle, state=IDLE, tx_ready=1 in that same cycle.
- bus_i and bus_c are registered outputs: no combinational path from any input to them.
- rx_valid and col_err are never high simultaneously; each is high for exactly one cycle per event.
- Nominal transaction length, handshake to rx_valid: 2*WIDTH*BIT_CYCLES + TURN_CYCLES + 1 cycles (67 with defaults).

Test Plan:
1. Reset defaults: hold rst_n=0 for 3 cycles, release -> tx_ready=1, bus_c=0, bus_i=0, rx_valid=0, col_err=0; assert rst_n mid-cycle -> outputs clear with no clock edge.
2. Loopback transmit: bus_in=bus_i while bus_c=1; tx_data=8'hA5 handshake at T0.
   - bus_c=1 during T1..T32; bus_i pattern 1,0,1,0,0,1,0,1, each bit held 4 cycles.
   - No col_err; bus_c=0 at T33..T34.
3. Full round trip: responder drives 8'h3C MSB-first, 4 cycles/bit, starting T35 -> rx_valid=1 at T67 only, rx_data=8'h3C, tx_ready=1 at T67.
4. Collision: tx_data=8'h80, force bus_in=0 throughout.
   - col_err=1 at T5; bus_c=0 from T5; tx_ready=1 at T7.
   - No rx_valid.
5. Busy ignore: pulse tx_valid with tx_data=8'hFF during DRIVE of 8'h12 -> transmitted pattern remains 8'h12; no second transaction starts.
6. Reset mid-LISTEN: assert rst_n=0 at T50 -> bus_c=0, no rx_valid; after release, a new 8'h5A transfer completes normally.

Source files
------------

// File: rtl/tri_bus_ctrl.sv
// Half-duplex serial controller feeding a tri-state buffer stage: drives a word MSB-first,
// releases the line for a turnaround gap, then samples the far end's reply.
//
// state  | meaning
// IDLE   | line released, tx_ready high, waiting for a handshake
// DRIVE  | buffer enabled, shifting the transmit word out, collision-checked per bit
// TURN   | line released for TURN_CYCLES before listening (or before IDLE after a collision)
// LISTEN | line released, sampling the reply at the end of every bit period
module tri_bus_ctrl #(
  parameter int WIDTH       = 8,
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             bus_i,
  output logic             bus_c,
  input  logic             bus_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             col_err
);

  localparam int CMAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN, LISTEN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-2:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] rx_next;
  logic             bus_i_q, bus_i_d;
  logic             bus_c_q, bus_c_d;
  logic             rx_valid_q, rx_valid_d;
  logic             col_err_q, col_err_d;
  logic             abort_q, abort_d;
  logic             sync_meta_q, sync_in_q;

  // Two-flop synchronizer on the asynchronous line readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_in_q   <= 1'b0;
    end else begin
      sync_meta_q <= bus_in;
      sync_in_q   <= sync_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bus_i_q    <= 1'b0;
      bus_c_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      col_err_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      bus_i_q    <= bus_i_d;
      bus_c_q    <= bus_c_d;
      rx_valid_q <= rx_valid_d;
      col_err_q  <= col_err_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bus_i_d    = bus_i_q;
    bus_c_d    = bus_c_q;
    rx_valid_d = 1'b0;
    col_err_d  = 1'b0;
    abort_d    = abort_q;
    rx_next    = {rx_sh_q, sync_in_q};

    case (state_q)
      IDLE: begin
        bus_i_d = 1'b0;
        bus_c_d = 1'b0;
        if (tx_valid) begin
          state_d = DRIVE;
          tx_sh_d = tx_data;
          bus_i_d = tx_data[WIDTH-1];
          bus_c_d = 1'b1;
          cyc_d   = '0;
          bit_d   = '0;
          abort_d = 1'b0;
        end
      end

      DRIVE: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          // Readback lags by the synchronizer depth; by the last cycle of a bit it has settled
          if (sync_in_q != bus_i_q) begin
            state_d   = TURN;
            col_err_d = 1'b1;
            abort_d   = 1'b1;
            bus_c_d   = 1'b0;
            bus_i_d   = 1'b0;
            bit_d     = '0;
          end else if (bit_q == WORD_LAST) begin
            state_d = TURN;
            bus_c_d = 1'b0;
            bus_i_d = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_sh_d = {tx_sh_q[WIDTH-2:0], tx_sh_q[WIDTH-1]};
            bus_i_d = tx_sh_q[WIDTH-2];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      TURN: begin
        if (cyc_q == TURN_LAST) begin
          cyc_d   = '0;
          state_d = abort_q ? IDLE : LISTEN;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      LISTEN: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          rx_sh_d = rx_next[WIDTH-2:0];
          if (bit_q == WORD_LAST) begin
            state_d    = IDLE;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_d      = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        bus_i_d = 1'b0;
        bus_c_d = 1'b0;
      end
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign bus_i    = bus_i_q;
  assign bus_c    = bus_c_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign col_err  = col_err_q;

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Directed bench for tri_bus_ctrl: loopback/responder line model, per-cycle expected
// waveform model and a queue of expected received words.
module tb_tri_bus_ctrl;
  localparam int W    = 8;
  localparam int BC   = 4;
  localparam int TC   = 2;
  localparam int XFER = 2*W*BC + TC + 1;
  localparam int LST0 = W*BC + TC + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         bus_i;
  logic         bus_c;
  logic         bus_in = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         col_err;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  tri_bus_ctrl #(.WIDTH(W), .BIT_CYCLES(BC), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_i(bus_i), .bus_c(bus_c), .bus_in(bus_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .col_err(col_err)
  );

  task automatic chk1(input string tag, input int t, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, t, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input int t, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int t);
    chk1({tag, "_ready"}, t, tx_ready, 1'b1);
    chk1({tag, "_bus_c"}, t, bus_c, 1'b0);
    chk1({tag, "_bus_i"}, t, bus_i, 1'b0);
    chk1({tag, "_rx_valid"}, t, rx_valid, 1'b0);
    chk1({tag, "_col_err"}, t, col_err, 1'b0);
    chkw({tag, "_rx_data"}, t, rx_data, '0);
  endtask

  // t counts cycles after the handshake edge; t=1 is the first DRIVE cycle.
  task automatic run(input logic [W-1:0] tx, input logic [W-1:0] resp, input bit force0,
                     input bit busy, input int rst_at, input int ncyc);
    int   col_t;
    bit   gone;
    logic e_c, e_i, e_rdy, e_rv, e_ce;
    col_t = 0;
    if (force0)
      for (int i = 0; i < W; i++)
        if (col_t == 0 && tx[W-1-i]) col_t = BC*(i+1) + 1;
    if (col_t == 0 && rst_at == 0) exp_q.push_back(resp);

    chk1("ready_pre", 0, tx_ready, 1'b1);
    bus_in   = 1'b0;
    tx_data  = tx;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;

    for (int t = 1; t <= ncyc; t++) begin
      if (t > 1) begin
        @(posedge clk); #1;
      end
      if (rst_at != 0 && t == rst_at + 2) rst_n = 1'b1;
      gone  = (rst_at != 0 && t > rst_at);
      e_c   = !gone && t <= W*BC && (col_t == 0 || t < col_t);
      e_i   = 1'b0;
      if (e_c) e_i = tx[W-1-(t-1)/BC];
      e_ce  = !gone && col_t != 0 && t == col_t;
      e_rv  = !gone && col_t == 0 && t == XFER;
      e_rdy = gone || ((col_t != 0) ? (t >= col_t + TC) : (t >= XFER));

      if (force0)                        bus_in = 1'b0;
      else if (bus_c)                    bus_in = bus_i;
      else if (t >= LST0 && t < LST0 + W*BC) bus_in = resp[W-1-(t-LST0)/BC];
      else                               bus_in = 1'b0;

      chk1("bus_c", t, bus_c, e_c);
      chk1("bus_i", t, bus_i, e_i);
      chk1("col_err", t, col_err, e_ce);
      chk1("rx_valid", t, rx_valid, e_rv);
      chk1("tx_ready", t, tx_ready, e_rdy);
      if (rx_valid === 1'b1) begin
        chk1("sb_nonempty", t, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chkw("rx_data", t, rx_data, exp_q.pop_front());
      end

      if (busy && t == 10) begin
        tx_data  = '1;
        tx_valid = 1'b1;
      end
      if (busy && t == 11) tx_valid = 1'b0;

      if (rst_at != 0 && t == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst", t);
      end
    end
    chk1("sb_drained", ncyc, exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle("reset_held", 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("reset_released", 0);

    run(8'hA5, 8'h3C, 1'b0, 1'b0, 0, 70);   // loopback drive plus full round trip
    run(8'h80, 8'h00, 1'b1, 1'b0, 0, 20);   // collision on the first bit
    run(8'h12, 8'h00, 1'b0, 1'b1, 0, 72);   // tx_valid while busy is ignored
    run(8'hA5, 8'h00, 1'b0, 1'b0, 3, 8);    // asynchronous reset mid-DRIVE
    run(8'h33, 8'h99, 1'b0, 1'b0, 50, 56);  // reset mid-LISTEN, no rx_valid
    run(8'h5A, 8'hC3, 1'b0, 1'b0, 0, 70);   // normal transfer after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
